// File: rtl/pipeline_pkg.sv
// Shared pipeline types: M/W stage FSM states, default widths, W-bundle layout.
package pipeline_pkg;

  localparam int DEFAULT_DATA_W     = 32;
  localparam int DEFAULT_REG_ADDR_W = 5;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  typedef struct packed {
    logic                          valid;
    logic                          reg_write;
    logic [DEFAULT_REG_ADDR_W-1:0] write_reg;
    logic [DEFAULT_DATA_W-1:0]     result;
  } w_bundle_t;

endpackage

// File: rtl/mem_wait_timer.sv
// Watchdog for outstanding memory accesses: counts stalled BUSY cycles and
// flags expiry on the cycle that would make the count reach MAX_WAIT.
module mem_wait_timer
  import pipeline_pkg::*;
#(
  parameter int MAX_WAIT = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam int CNT_W = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(MAX_WAIT - 1);

  logic [CNT_W-1:0] count;

  // Count enabled cycles; clearing takes priority so each access starts from zero.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      count <= '0;
    else if (clear)
      count <= '0;
    else if (enable)
      count <= count + 1'b1;
  end

  assign expire = enable && (count == LAST);

endmodule

// File: rtl/mem_writeback_stage.sv
// Memory-access and writeback stage: issues loads/stores with a ready
// handshake, stalls M while busy, drives the registered W bundle, and retires
// hung accesses through a watchdog with a sticky bus error.
module mem_writeback_stage
  import pipeline_pkg::*;
#(
  parameter int DATA_W     = DEFAULT_DATA_W,
  parameter int REG_ADDR_W = DEFAULT_REG_ADDR_W,
  parameter int MAX_WAIT   = 255
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  valid_m,
  input  logic                  reg_write_m,
  input  logic                  mem_to_reg_m,
  input  logic                  mem_write_m,
  input  logic [DATA_W-1:0]     alu_out_m,
  input  logic [DATA_W-1:0]     write_data_m,
  input  logic [REG_ADDR_W-1:0] write_reg_m,
  output logic                  stall_m,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [DATA_W-1:0]     mem_addr,
  output logic [DATA_W-1:0]     mem_wdata,
  input  logic [DATA_W-1:0]     mem_rdata,
  input  logic                  mem_ready,
  output logic                  valid_w,
  output logic                  reg_write_w,
  output logic [REG_ADDR_W-1:0] write_reg_w,
  output logic [DATA_W-1:0]     result_w,
  output logic                  bus_err
);

  state_t                state, state_next;
  logic                  mem_op;
  logic                  expire;
  logic                  hold_load;
  logic                  hold_reg_write;
  logic [REG_ADDR_W-1:0] hold_write_reg;

  assign mem_op  = valid_m & (mem_to_reg_m | mem_write_m);
  assign mem_req = (state == BUSY);

  mem_wait_timer #(.MAX_WAIT(MAX_WAIT)) u_timer (
    .clk    (clk),
    .reset  (reset),
    .clear  (state == IDLE),
    .enable ((state == BUSY) & ~mem_ready),
    .expire (expire)
  );

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      state <= IDLE;
    else
      state <= state_next;
  end

  // Next state and the combinational stall back to the M stage.
  always_comb begin
    state_next = state;
    stall_m    = 1'b0;
    case (state)
      IDLE: begin
        if (mem_op) begin
          stall_m    = 1'b1;
          state_next = BUSY;
        end
      end
      BUSY: begin
        stall_m = ~mem_ready;
        if (mem_ready || expire)
          state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Access hold registers and the W bundle; a ready response beats expiry.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_we         <= 1'b0;
      mem_addr       <= '0;
      mem_wdata      <= '0;
      hold_load      <= 1'b0;
      hold_reg_write <= 1'b0;
      hold_write_reg <= '0;
      valid_w        <= 1'b0;
      reg_write_w    <= 1'b0;
      write_reg_w    <= '0;
      result_w       <= '0;
      bus_err        <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (mem_op) begin
            mem_addr       <= alu_out_m;
            mem_wdata      <= write_data_m;
            mem_we         <= ~mem_to_reg_m;
            hold_load      <= mem_to_reg_m;
            hold_reg_write <= reg_write_m;
            hold_write_reg <= write_reg_m;
            valid_w        <= 1'b0;
            reg_write_w    <= 1'b0;
          end else begin
            valid_w     <= valid_m;
            reg_write_w <= valid_m & reg_write_m & (write_reg_m != '0);
            write_reg_w <= write_reg_m;
            result_w    <= alu_out_m;
          end
        end
        BUSY: begin
          if (mem_ready) begin
            valid_w     <= 1'b1;
            write_reg_w <= hold_write_reg;
            result_w    <= hold_load ? mem_rdata : mem_addr;
            reg_write_w <= hold_reg_write & hold_load & (hold_write_reg != '0);
            mem_we      <= 1'b0;
          end else if (expire) begin
            valid_w     <= 1'b1;
            write_reg_w <= hold_write_reg;
            result_w    <= '0;
            reg_write_w <= 1'b0;
            bus_err     <= 1'b1;
            mem_we      <= 1'b0;
          end else begin
            valid_w     <= 1'b0;
            reg_write_w <= 1'b0;
          end
        end
        default: begin
          valid_w     <= 1'b0;
          reg_write_w <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_writeback_stage.sv
// Self-checking bench for mem_writeback_stage: directed cases followed by
// randomized operations, each checked against per-operation expectations.
module tb_mem_writeback_stage;

  localparam int MAXW = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        valid_m, reg_write_m, mem_to_reg_m, mem_write_m;
  logic [31:0] alu_out_m, write_data_m;
  logic [4:0]  write_reg_m;
  logic        stall_m, mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_ready;
  logic        valid_w, reg_write_w;
  logic [4:0]  write_reg_w;
  logic [31:0] result_w;
  logic        bus_err;

  int   vectors     = 0;
  int   miscompares = 0;
  logic exp_bus_err = 1'b0;

  mem_writeback_stage #(.DATA_W(32), .REG_ADDR_W(5), .MAX_WAIT(MAXW)) dut (
    .clk          (clk),
    .reset        (reset),
    .valid_m      (valid_m),
    .reg_write_m  (reg_write_m),
    .mem_to_reg_m (mem_to_reg_m),
    .mem_write_m  (mem_write_m),
    .alu_out_m    (alu_out_m),
    .write_data_m (write_data_m),
    .write_reg_m  (write_reg_m),
    .stall_m      (stall_m),
    .mem_req      (mem_req),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata),
    .mem_ready    (mem_ready),
    .valid_w      (valid_w),
    .reg_write_w  (reg_write_w),
    .write_reg_w  (write_reg_w),
    .result_w     (result_w),
    .bus_err      (bus_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic idle_bundle();
    valid_m      = 1'b0;
    reg_write_m  = 1'b0;
    mem_to_reg_m = 1'b0;
    mem_write_m  = 1'b0;
    alu_out_m    = $urandom;
    write_data_m = $urandom;
    write_reg_m  = 5'($urandom);
  endtask

  task automatic idle_cycle();
    idle_bundle();
    mem_ready = 1'($urandom);
    @(negedge clk);
    chk("stall_idle", stall_m, 1'b0);
    @(posedge clk); #1;
    chk("valid_w_idle", valid_w, 1'b0);
    chk("reg_write_w_idle", reg_write_w, 1'b0);
    chk("mem_req_idle", mem_req, 1'b0);
    mem_ready = 1'b0;
  endtask

  // One operation from acceptance to retire. delay = number of BUSY cycles
  // before mem_ready; delay >= MAXW means the memory never answers.
  task automatic run_op(input bit ld, input bit st, input bit rw, input logic [4:0] rd,
                        input logic [31:0] alu, input logic [31:0] wd,
                        input logic [31:0] rdata, input int delay);
    bit memop;
    bit rdy;
    memop        = ld | st;
    valid_m      = 1'b1;
    mem_to_reg_m = ld;
    mem_write_m  = st;
    reg_write_m  = rw;
    write_reg_m  = rd;
    alu_out_m    = alu;
    write_data_m = wd;
    mem_ready    = 1'($urandom);
    mem_rdata    = $urandom;
    @(negedge clk);
    chk("stall_accept", stall_m, memop);
    @(posedge clk); #1;
    if (!memop) begin
      idle_bundle();
      mem_ready = 1'b0;
      chk("alu_valid_w", valid_w, 1'b1);
      chk("alu_result_w", result_w, alu);
      chk("alu_write_reg_w", write_reg_w, rd);
      chk("alu_reg_write_w", reg_write_w, rw && (rd != 5'd0));
      chk("alu_bus_err", bus_err, exp_bus_err);
      return;
    end
    chk("mem_req_rise", mem_req, 1'b1);
    chk("mem_we", mem_we, !ld);
    chk("mem_addr", mem_addr, alu);
    if (!ld) chk("mem_wdata", mem_wdata, wd);
    chk("bubble_valid_w", valid_w, 1'b0);
    chk("bubble_reg_write_w", reg_write_w, 1'b0);
    for (int k = 0; k < MAXW; k++) begin
      rdy       = (k == delay);
      mem_ready = rdy;
      mem_rdata = rdy ? rdata : $urandom;
      @(negedge clk);
      chk("stall_busy", stall_m, !rdy);
      chk("mem_req_busy", mem_req, 1'b1);
      chk("mem_addr_busy", mem_addr, alu);
      @(posedge clk); #1;
      if (rdy || k == MAXW - 1) begin
        idle_bundle();
        mem_ready = 1'b0;
        if (!rdy) exp_bus_err = 1'b1;
        chk("retire_valid_w", valid_w, 1'b1);
        chk("retire_write_reg_w", write_reg_w, rd);
        chk("retire_result_w", result_w, rdy ? (ld ? rdata : alu) : 32'h0);
        chk("retire_reg_write_w", reg_write_w, rdy && ld && rw && (rd != 5'd0));
        chk("retire_bus_err", bus_err, exp_bus_err);
        chk("mem_req_drop", mem_req, 1'b0);
        break;
      end else begin
        chk("wait_valid_w", valid_w, 1'b0);
      end
    end
  endtask

  initial begin
    int kind;
    bit ld, st;
    reset     = 1'b1;
    mem_ready = 1'b0;
    mem_rdata = '0;
    idle_bundle();
    #2;
    chk("rst_mem_req", mem_req, 1'b0);
    chk("rst_mem_we", mem_we, 1'b0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_mem_wdata", mem_wdata, 32'h0);
    chk("rst_valid_w", valid_w, 1'b0);
    chk("rst_reg_write_w", reg_write_w, 1'b0);
    chk("rst_write_reg_w", write_reg_w, 5'd0);
    chk("rst_result_w", result_w, 32'h0);
    chk("rst_bus_err", bus_err, 1'b0);
    chk("rst_stall_idle", stall_m, 1'b0);
    valid_m      = 1'b1;
    mem_to_reg_m = 1'b1;
    #1;
    chk("rst_stall_memop", stall_m, 1'b1);
    idle_bundle();
    #9 reset = 1'b0;
    @(posedge clk); #1;

    run_op(1'b0, 1'b0, 1'b1, 5'd3, 32'h1234, 32'h0, 32'h0, 0);
    idle_cycle();
    run_op(1'b1, 1'b0, 1'b1, 5'd7, 32'h40, 32'h0, 32'hDEADBEEF, 3);
    idle_cycle();
    run_op(1'b0, 1'b1, 1'b1, 5'd9, 32'h80, 32'hCAFE, 32'h0, 0);
    run_op(1'b0, 1'b0, 1'b1, 5'd0, 32'h5555, 32'h0, 32'h0, 0);
    run_op(1'b1, 1'b1, 1'b1, 5'd12, 32'h100, 32'h77, 32'h0BADF00D, MAXW - 1);
    idle_cycle();
    run_op(1'b1, 1'b0, 1'b1, 5'd4, 32'h200, 32'h0, 32'h0, MAXW);
    idle_cycle();
    run_op(1'b0, 1'b0, 1'b1, 5'd5, 32'h99, 32'h0, 32'h0, 0);

    for (int i = 0; i < 150; i++) begin
      kind = $urandom_range(0, 3);
      ld   = (kind == 1) || (kind == 3);
      st   = (kind == 2) || (kind == 3);
      run_op(ld, st, 1'($urandom), 5'($urandom), $urandom, $urandom, $urandom,
             $urandom_range(0, MAXW));
      if ($urandom_range(0, 1) == 1) idle_cycle();
    end

    valid_m      = 1'b1;
    mem_to_reg_m = 1'b1;
    mem_write_m  = 1'b0;
    reg_write_m  = 1'b1;
    write_reg_m  = 5'd6;
    alu_out_m    = 32'h300;
    mem_ready    = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #3;
    chk("pre_reset_mem_req", mem_req, 1'b1);
    reset       = 1'b1;
    exp_bus_err = 1'b0;
    #1;
    chk("midrst_mem_req", mem_req, 1'b0);
    chk("midrst_valid_w", valid_w, 1'b0);
    chk("midrst_bus_err", bus_err, 1'b0);
    idle_bundle();
    @(negedge clk);
    #2 reset = 1'b0;
    mem_ready = 1'b1;
    mem_rdata = 32'h12345678;
    @(posedge clk); #1;
    chk("postrst_valid_w", valid_w, 1'b0);
    chk("postrst_mem_req", mem_req, 1'b0);
    mem_ready = 1'b0;
    run_op(1'b0, 1'b0, 1'b1, 5'd0, 32'hABCD, 32'h0, 32'h0, 0);
    run_op(1'b0, 1'b0, 1'b1, 5'd2, 32'h1111, 32'h0, 32'h0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
